rr_mux4_select_ctrl: RTL and testbench

Round-robin select controller that sits directly upstream of the 4:1 mux select input and drives its 2-bit s. It arbitrates four per-channel requests and holds the grant for a bounded burst. It also registers the mux output f with a channel tag so downstream logic receives a sampled, qualified bit stream.

---
 rtl/rr_mux4_select_ctrl.sv | 69 ++++++
 tb/tb_rr_mux4_select_ctrl.sv | 99 +++++++++
 2 files changed

// File: rtl/rr_mux4_select_ctrl.sv
// rr_mux4_select_ctrl: round-robin 4:1 mux select arbiter with bounded hold and registered, channel-tagged sampling of the mux output
module rr_mux4_select_ctrl #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [1:0] s,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  input  logic       f_in,
  output logic       f_q,
  output logic [1:0] f_ch,
  output logic       f_q_valid
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [1:0] s_q, s_d, last_q, last_d, f_ch_q, f_ch_d, win, idx;
  logic [3:0] gnt_q, gnt_d, mask;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic f_d, f_q_valid_q, f_q_valid_d, rel, grab, keep;
  always_comb begin
    rel = state_q == GRANT && (!req[s_q] || cnt_q == CNT_W'(HOLD_CYCLES - 1));
    mask = state_q == GRANT ? req & ~gnt_q : req;
    win = last_q;
    idx = last_q;
    for (int k = 4; k >= 1; k--) begin
      idx = last_q + 2'(k);
      if (mask[idx]) win = idx;
    end
    grab = (state_q == IDLE || rel) && |mask;
    keep = rel && !(|mask) && req[s_q];
    state_d = grab || (state_q == GRANT && (!rel || keep)) ? GRANT : IDLE;
    s_d = grab ? win : s_q;
    gnt_d = grab ? 4'b0001 << win : state_d == GRANT ? gnt_q : 4'b0000;
    cnt_d = grab || keep || state_d == IDLE ? '0 : cnt_q + CNT_W'(1);
    last_d = grab ? win : last_q;
    f_d = f_in;
    f_ch_d = s_q;
    f_q_valid_d = |gnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q <= '0;
      gnt_q <= '0;
      cnt_q <= '0;
      last_q <= 2'd3;
      f_q <= 1'b0;
      f_ch_q <= '0;
      f_q_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      f_q <= f_d;
      f_ch_q <= f_ch_d;
      f_q_valid_q <= f_q_valid_d;
    end
  end
  assign s = s_q;
  assign gnt = gnt_q;
  assign gnt_valid = |gnt_q;
  assign f_ch = f_ch_q;
  assign f_q_valid = f_q_valid_q;
endmodule

// File: tb/tb_rr_mux4_select_ctrl.sv
// tb_rr_mux4_select_ctrl: directed checks of arbitration, hold bound, idle return, reset and sampling
module tb_rr_mux4_select_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = '0, req1 = '0, gnt, gnt1;
  logic [3:0] mux_i = 4'b1010;
  logic [1:0] s, s1, f_ch, f_ch1;
  logic gv, gv1, f_q, f_q1, fqv, fqv1, f_in, f_in1;
  int errors = 0, checks = 0;
  assign f_in = mux_i[s];
  assign f_in1 = mux_i[s1];
  always #5 clk = ~clk;
  rr_mux4_select_ctrl #(.HOLD_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .req(req), .s(s), .gnt(gnt), .gnt_valid(gv),
    .f_in(f_in), .f_q(f_q), .f_ch(f_ch), .f_q_valid(fqv)
  );
  rr_mux4_select_ctrl #(.HOLD_CYCLES(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .s(s1), .gnt(gnt1), .gnt_valid(gv1),
    .f_in(f_in1), .f_q(f_q1), .f_ch(f_ch1), .f_q_valid(fqv1)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    tick;
    tick;
    chk("rst_s", 32'(s), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_gv", 32'(gv), 0);
    chk("rst_fqv", 32'(fqv), 0);
    rst = 1'b0;
    req = 4'b0100;
    tick;
    chk("single_first_gnt", 32'(gnt), 32'h4);
    chk("single_first_s", 32'(s), 2);
    for (int i = 0; i < 9; i++) begin
      tick;
      chk($sformatf("single_gnt_%0d", i), 32'(gnt), 32'h4);
      chk($sformatf("single_s_%0d", i), 32'(s), 2);
    end
    chk("single_fqv", 32'(fqv), 1);
    chk("single_fch", 32'(f_ch), 2);
    rst = 1'b1;
    #1;
    chk("async_rst_s", 32'(s), 0);
    chk("async_rst_gnt", 32'(gnt), 0);
    chk("async_rst_gv", 32'(gv), 0);
    chk("async_rst_fqv", 32'(fqv), 0);
    #2;
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      tick;
      chk($sformatf("rot_gnt_%0d", i), 32'(gnt), 32'(4'b0001 << ((i / 4) % 4)));
      chk($sformatf("rot_gv_%0d", i), 32'(gv), 1);
    end
    tick;
    chk("early_own1", 32'(gnt), 32'h2);
    tick;
    chk("early_own1_hold", 32'(gnt), 32'h2);
    req = 4'b1001;
    tick;
    chk("early_next_gnt", 32'(gnt), 32'h8);
    chk("early_next_s", 32'(s), 3);
    req = 4'b0100;
    tick;
    chk("idle_pre_gnt", 32'(gnt), 32'h4);
    req = 4'b0000;
    tick;
    chk("idle_gnt", 32'(gnt), 0);
    chk("idle_gv", 32'(gv), 0);
    chk("idle_s_hold", 32'(s), 2);
    chk("idle_fqv_lag", 32'(fqv), 1);
    req = 4'b0001;
    tick;
    chk("idle_regrant_gnt", 32'(gnt), 32'h1);
    chk("idle_regrant_s", 32'(s), 0);
    chk("idle_regrant_fqv", 32'(fqv), 0);
    req1 = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      tick;
      chk($sformatf("samp_s_%0d", i), 32'(s1), 32'(i % 4));
      chk($sformatf("samp_fqv_%0d", i), 32'(fqv1), 32'(i != 0));
      if (i != 0) begin
        chk($sformatf("samp_fch_%0d", i), 32'(f_ch1), 32'((i - 1) % 4));
        chk($sformatf("samp_fq_%0d", i), 32'(f_q1), 32'(((i - 1) % 4) & 1));
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
